wptr_full_level: RTL and testbench

- Write-side pointer and full-flag controller for the dual-clock Gray-pointer asynchronous FIFO.
- Owns the write binary/Gray pointers and produces the memory write address.
- Generates the registered full, almost-full, write-side fill level and sticky overflow flags from the read pointer already synchronized into the write domain.
- Sits in the write clock domain, between the write client, the dual-port FIFO memory and the read-to-write pointer synchronizer.

---
 rtl/fifo_pkg.sv | 19 +
 rtl/wptr_full_level.sv | 72 +++++++
 tb/tb_wptr_full_level.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Gray/binary pointer helpers shared by the write- and read-side FIFO controllers.
// Arguments are zero-extended pointers of any width up to 32 bits; callers size-cast the result back.
package fifo_pkg;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR from the MSB down. Zero upper bits do not affect the low bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_level.sv
// Write-domain pointer, full/almost-full, fill-level and sticky-overflow controller for the
// Gray-pointer async FIFO. wq2_rptr arrives already synchronized into wclk.
module wptr_full_level
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int PW    = ADDRSIZE + 1;
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

    if (ADDRSIZE < 2 || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_param_check
        $error("wptr_full_level: illegal ADDRSIZE/AFULL_THRESH");
    end

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] wlevel_next;
    logic          winc_ok;
    logic          wovf_set;
    logic          wfull_val;
    logic          wafull_val;

    assign winc_ok     = winc & ~wfull;
    assign wovf_set    = winc & wfull;
    assign wbinnext    = wbin + PW'(winc_ok);
    assign wgraynext   = PW'(bin2gray(32'(wbinnext)));
    assign rbin_s      = PW'(gray2bin(32'(wq2_rptr)));
    // Modulo subtraction; the stale read pointer makes this an over-estimate, never an under-estimate.
    assign wlevel_next = wbinnext - rbin_s;

    // Full when the next write pointer equals the read pointer with the two MSBs inverted (Gray form).
    assign wfull_val  = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    assign wafull_val = (wlevel_next >= AFULL_T);

    assign waddr = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
            wlevel <= '0;
            wovf   <= 1'b0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= wfull_val;
            wafull <= wafull_val;
            wlevel <= wlevel_next;
            wovf   <= wovf_clr ? wovf_set : (wovf | wovf_set);
        end
    end

endmodule

// File: tb/tb_wptr_full_level.sv
// Scoreboard bench for wptr_full_level: a behavioural occupancy model queues the expected
// registered outputs as each cycle's stimulus is driven; they are popped after the edge.
module tb_wptr_full_level;

    localparam int AW = 4;
    localparam int PW = AW + 1;

    logic          wclk;
    logic          wrst_n;
    logic          winc;
    logic [PW-1:0] wq2_rptr;
    logic          wovf_clr;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          wfull;
    logic          wafull;
    logic [PW-1:0] wlevel;
    logic          wovf;

    wptr_full_level #(.ADDRSIZE(AW), .AFULL_THRESH(12)) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .winc     (winc),
        .wq2_rptr (wq2_rptr),
        .wovf_clr (wovf_clr),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .wafull   (wafull),
        .wlevel   (wlevel),
        .wovf     (wovf)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        string tag;
        int    wptr;
        int    waddr;
        int    full;
        int    afull;
        int    level;
        int    ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Occupancy model: write count, read count (binary), flags.
    int m_wb   = 0;
    int m_rb   = 0;
    int m_full = 0;
    int m_ovf  = 0;

    function automatic int gray5(input int b);
        int x;
        x = b & 31;
        return x ^ (x >> 1);
    endfunction

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wb   = 0;
        m_rb   = 0;
        m_full = 0;
        m_ovf  = 0;
    endtask

    // One write-clock cycle: drive inputs, predict, wait for the edge, compare.
    task automatic step(input string tag, input bit w, input int rb, input bit clr);
        exp_t e;
        int   acc;
        int   nb;
        int   lvl;
        winc     = w;
        wovf_clr = clr;
        m_rb     = rb & 31;
        wq2_rptr = PW'(gray5(m_rb));
        acc      = (w && m_full == 0) ? 1 : 0;
        nb       = (m_wb + acc) & 31;
        lvl      = (nb - m_rb) & 31;
        m_ovf    = (w && m_full != 0) ? 1 : (clr ? 0 : m_ovf);
        m_wb     = nb;
        m_full   = (lvl == 16) ? 1 : 0;
        e.tag    = tag;
        e.wptr   = gray5(nb);
        e.waddr  = nb & 15;
        e.full   = m_full;
        e.afull  = (lvl >= 12) ? 1 : 0;
        e.level  = lvl;
        e.ovf    = m_ovf;
        sb.push_back(e);
        @(posedge wclk);
        #1;
        if (sb.size() == 0) begin
            check_val({tag, ".sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check_val({e.tag, ".wptr"},   int'(wptr),   e.wptr);
            check_val({e.tag, ".waddr"},  int'(waddr),  e.waddr);
            check_val({e.tag, ".wfull"},  int'(wfull),  e.full);
            check_val({e.tag, ".wafull"}, int'(wafull), e.afull);
            check_val({e.tag, ".wlevel"}, int'(wlevel), e.level);
            check_val({e.tag, ".wovf"},   int'(wovf),   e.ovf);
        end
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".wptr"},   int'(wptr),   0);
        check_val({tag, ".waddr"},  int'(waddr),  0);
        check_val({tag, ".wfull"},  int'(wfull),  0);
        check_val({tag, ".wafull"}, int'(wafull), 0);
        check_val({tag, ".wlevel"}, int'(wlevel), 0);
        check_val({tag, ".wovf"},   int'(wovf),   0);
    endtask

    initial begin
        int rb;
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
        model_reset();
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        check_zero("reset_hold");
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        check_zero("reset_rel");

        // Fill 16 entries with the reader idle.
        for (int i = 1; i <= 16; i++) begin
            step($sformatf("fill%0d", i), 1'b1, 0, 1'b0);
            if (i == 12) begin
                check_val("fill12.level_abs", int'(wlevel), 12);
                check_val("fill12.afull_abs", int'(wafull), 1);
            end
        end
        check_val("full.wptr_abs", int'(wptr), 5'b11000);
        check_val("full.level_abs", int'(wlevel), 16);

        // Overflow: write while full, sticky, clear, then set+clear together.
        step("ovf_set",   1'b1, 0, 1'b0);
        check_val("ovf.wptr_abs", int'(wptr), 5'b11000);
        step("ovf_hold",  1'b0, 0, 1'b0);
        step("ovf_clr",   1'b0, 0, 1'b1);
        step("ovf_setclr", 1'b1, 0, 1'b1);
        check_val("ovf_setclr.abs", int'(wovf), 1);
        step("ovf_clr2",  1'b0, 0, 1'b1);

        // Drain: synchronized read pointer jumps in one Gray step per cycle.
        for (int r = 1; r <= 4; r++) step($sformatf("drain_r%0d", r), 1'b0, r, 1'b0);
        check_val("drain4.full_abs",  int'(wfull),  0);
        check_val("drain4.level_abs", int'(wlevel), 12);
        check_val("drain4.afull_abs", int'(wafull), 1);
        step("drain_r5", 1'b0, 5, 1'b0);
        check_val("drain5.level_abs", int'(wlevel), 11);
        check_val("drain5.afull_abs", int'(wafull), 0);

        // Async reset between edges must clear everything without a clock.
        #3;
        wrst_n = 1'b0;
        #1;
        check_zero("async_rst");
        winc     = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
        model_reset();
        @(negedge wclk);
        wrst_n = 1'b1;
        @(posedge wclk);
        #1;
        check_zero("post_rst");

        // Wrap: reader follows the previous write pointer; 40 writes pass 31->0.
        for (int i = 0; i < 40; i++) begin
            step($sformatf("wrap%0d", i), 1'b1, m_wb, 1'b0);
            if (wfull !== 1'b0 || wlevel > 1) check_val("wrap.level_range", int'(wlevel), 1);
        end
        check_val("wrap.wptr_abs",  int'(wptr),  5'b01100);
        check_val("wrap.waddr_abs", int'(waddr), 8);

        // Threshold edge: fill to 11, then mix write+read, write-only, read-only.
        rb = m_rb;
        while (((m_wb - rb) & 31) < 11) step("thr_fill", 1'b1, rb, 1'b0);
        check_val("thr11.afull_abs", int'(wafull), 0);
        for (int i = 0; i < 18; i++) begin
            case (i % 3)
                0: begin rb = rb + 1; step("thr_wr_rd", 1'b1, rb, 1'b0); end
                1: step("thr_wr", 1'b1, rb, 1'b0);
                default: begin rb = rb + 1; step("thr_rd", 1'b0, rb, 1'b0); end
            endcase
        end

        check_val("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
